// File: rtl/io_input_entry.sv
// io_input_entry: assembles a signed 3-digit BCD entry and publishes it as two's complement on value_out/flag_out.
// Latency: key_enter at edge N -> flag_out and value_out valid after edge N+4; flag_out drops the cycle after ack/key_clear.
// Backpressure: level handshake, value held in READY until ack or key_clear (or auto-release when ENTRY_TIMEOUT_EN is defined).
module io_input_entry #(
  parameter int DATA_W         = 15,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        digit_in,
  input  logic              digit_valid,
  input  logic              key_sign,
  input  logic              key_enter,
  input  logic              key_clear,
  input  logic              ack,
  output logic [DATA_W-1:0] value_out,
  output logic              flag_out,
  output logic              ent_sign,
  output logic [3:0]        ent_hund,
  output logic [3:0]        ent_tens,
  output logic [3:0]        ent_units,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_ENTRY = 3'd0,
    ST_CONV1 = 3'd1,
    ST_CONV2 = 3'd2,
    ST_CONV3 = 3'd3,
    ST_READY = 3'd4
  } state_t;

  state_t            state_q;
  logic [3:0]        hund_q, tens_q, units_q;
  logic              sign_q;
  logic [9:0]        acc_q;
  logic [DATA_W-1:0] value_q;
  logic              flag_q;

  // Shift-add constant multiplies: x*100 = x*64 + x*32 + x*4, x*10 = x*8 + x*2.
  logic [9:0] hund_x100, tens_x10;
  assign hund_x100 = (10'(hund_q) << 6) + (10'(hund_q) << 5) + (10'(hund_q) << 2);
  assign tens_x10  = (10'(tens_q) << 3) + (10'(tens_q) << 1);

  // Magnitude widened before negation so -0 naturally yields 0.
  logic [DATA_W-1:0] mag_ext, value_d;
  assign mag_ext = DATA_W'(acc_q);
  assign value_d = sign_q ? (-mag_ext) : mag_ext;

  logic timeout_hit;
  logic ready_exit;
  assign ready_exit = ack | key_clear | timeout_hit;

`ifdef ENTRY_TIMEOUT_EN
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);
  logic [31:0] tmo_cnt_q;

  // Cycle counter that runs only while the value sits in READY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_READY && !ready_exit) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == ST_READY) && (tmo_cnt_q == TMO_LIMIT);
`else
  logic unused_tmo;
  assign unused_tmo  = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
`endif

  // Entry/conversion/handshake FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ENTRY;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      value_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (key_clear) begin
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            sign_q  <= 1'b0;
          end else if (key_enter) begin
            state_q <= ST_CONV1;
          end else if (key_sign) begin
            sign_q <= ~sign_q;
          end else if (digit_valid && digit_in <= 4'd9) begin
            hund_q  <= tens_q;
            tens_q  <= units_q;
            units_q <= digit_in;
          end
        end
        ST_CONV1, ST_CONV2, ST_CONV3: begin
          if (key_clear) begin
            // Abort: drop the partial result, keep the last published value.
            state_q <= ST_ENTRY;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            sign_q  <= 1'b0;
          end else if (state_q == ST_CONV1) begin
            acc_q   <= hund_x100;
            state_q <= ST_CONV2;
          end else if (state_q == ST_CONV2) begin
            acc_q   <= acc_q + tens_x10;
            state_q <= ST_CONV3;
          end else begin
            acc_q   <= acc_q + 10'(units_q);
            state_q <= ST_READY;
          end
        end
        ST_READY: begin
          if (ready_exit) begin
            state_q <= ST_ENTRY;
            flag_q  <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            sign_q  <= 1'b0;
          end else begin
            // Value and flag are published together on the first READY edge.
            flag_q <= 1'b1;
            if (!flag_q) begin
              value_q <= value_d;
            end
          end
        end
        default: begin
          state_q <= ST_ENTRY;
          flag_q  <= 1'b0;
        end
      endcase
    end
  end

  assign value_out = value_q;
  assign flag_out  = flag_q;
  assign ent_sign  = sign_q;
  assign ent_hund  = hund_q;
  assign ent_tens  = tens_q;
  assign ent_units = units_q;
  assign busy      = (state_q != ST_ENTRY);

endmodule

// File: tb/tb_io_input_entry.sv
// Bench for io_input_entry: directed vector table, reset/hold corner sequences, and randomized run against a reference model.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
// Define ENTRY_TIMEOUT_EN on both files to exercise the auto-release path (TIMEOUT_CYCLES = 8 here).
module tb_io_input_entry;

  localparam int DW  = 15;
  localparam int TMO = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    digit_in;
  logic          digit_valid, key_sign, key_enter, key_clear, ack;
  logic [DW-1:0] value_out;
  logic          flag_out, ent_sign, busy;
  logic [3:0]    ent_hund, ent_tens, ent_units;

  int checks = 0;
  int errors = 0;

  io_input_entry #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
    .key_sign(key_sign), .key_enter(key_enter), .key_clear(key_clear), .ack(ack),
    .value_out(value_out), .flag_out(flag_out), .ent_sign(ent_sign),
    .ent_hund(ent_hund), .ent_tens(ent_tens), .ent_units(ent_units), .busy(busy)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  typedef struct {
    logic          dv;
    logic [3:0]    d;
    logic          s, en, cl, ak;
    logic          ef;
    logic [DW-1:0] ev;
    logic          eb, es;
    logic [3:0]    eh, et, eu;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic dv, input logic [3:0] d, input logic s, input logic en,
                     input logic cl, input logic ak, input logic ef, input logic [DW-1:0] ev,
                     input logic eb, input logic es, input logic [3:0] eh, input logic [3:0] et,
                     input logic [3:0] eu);
    vec_t v;
    v.dv = dv; v.d = d; v.s = s; v.en = en; v.cl = cl; v.ak = ak;
    v.ef = ef; v.ev = ev; v.eb = eb; v.es = es; v.eh = eh; v.et = et; v.eu = eu;
    vq.push_back(v);
  endtask

  task automatic drive(input logic dv, input logic [3:0] d, input logic s, input logic en,
                       input logic cl, input logic ak);
    digit_valid = dv; digit_in = d; key_sign = s; key_enter = en; key_clear = cl; ack = ak;
  endtask

  // One clock: inputs held across the edge, then pulses dropped.
  task automatic tick;
    @(posedge clock);
    #1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string name, input logic ef, input logic [DW-1:0] ev,
                           input logic eb, input logic es, input logic [3:0] eh,
                           input logic [3:0] et, input logic [3:0] eu);
    checks++;
    if ({flag_out, value_out, busy, ent_sign, ent_hund, ent_tens, ent_units} !==
        {ef, ev, eb, es, eh, et, eu}) begin
      errors++;
      $display("FAIL %s: got flag=%0b value=%h busy=%0b ent=%0b/%0d%0d%0d, expected flag=%0b value=%h busy=%0b ent=%0b/%0d%0d%0d",
               name, flag_out, value_out, busy, ent_sign, ent_hund, ent_tens, ent_units,
               ef, ev, eb, es, eh, et, eu);
    end
  endtask

  task automatic enter_num(input int h, input int t, input int u);
    drive(1'b1, 4'(h), 1'b0, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, 4'(t), 1'b0, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, 4'(u), 1'b0, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick;
  endtask

  // Reference model: digits as integers, e = edges elapsed since the enter edge (-1 = entering).
  int m_h, m_t, m_u, m_s, m_e;
  logic [DW-1:0] m_val;

  function automatic logic [DW-1:0] signed_value(input int s, input int h, input int t, input int u);
    int mag;
    mag = h * 100 + t * 10 + u;
    return DW'(s ? -mag : mag);
  endfunction

  task automatic model_reset;
    m_h = 0; m_t = 0; m_u = 0; m_s = 0; m_e = -1; m_val = '0;
  endtask

  task automatic model_step(input logic dv, input int d, input logic s, input logic en,
                            input logic cl, input logic ak);
    bit leave;
    if (m_e < 0) begin
      if (cl) begin m_h = 0; m_t = 0; m_u = 0; m_s = 0; end
      else if (en) m_e = 0;
      else if (s) m_s = 1 - m_s;
      else if (dv && d <= 9) begin m_h = m_t; m_t = m_u; m_u = d; end
    end else if (m_e <= 2) begin
      if (cl) begin m_h = 0; m_t = 0; m_u = 0; m_s = 0; m_e = -1; end
      else m_e++;
    end else begin
      leave = ak || cl;
`ifdef ENTRY_TIMEOUT_EN
      if (m_e == 3 + TMO) leave = 1'b1;
`endif
      if (leave) begin m_h = 0; m_t = 0; m_u = 0; m_s = 0; m_e = -1; end
      else begin
        m_e++;
        if (m_e == 4) m_val = signed_value(m_s, m_h, m_t, m_u);
      end
    end
  endtask

  initial begin
    int hi;
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_out("reset_state", 0, '0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;

    // Directed vector table: {inputs dv,d,sign,enter,clear,ack} -> {flag,value,busy,sign,h,t,u}.
    add(1, 1, 0,0,0,0, 0, 15'h0000, 0,0, 0,0,1);
    add(1, 2, 0,0,0,0, 0, 15'h0000, 0,0, 0,1,2);
    add(1, 3, 0,0,0,0, 0, 15'h0000, 0,0, 1,2,3);
    add(0, 0, 0,1,0,0, 0, 15'h0000, 1,0, 1,2,3);
    add(0, 0, 0,0,0,0, 0, 15'h0000, 1,0, 1,2,3);
    add(0, 0, 0,0,0,0, 0, 15'h0000, 1,0, 1,2,3);
    add(0, 0, 0,0,0,0, 0, 15'h0000, 1,0, 1,2,3);
    add(0, 0, 0,0,0,0, 1, 15'h007B, 1,0, 1,2,3);
    add(0, 0, 0,0,0,1, 0, 15'h007B, 0,0, 0,0,0);
    add(0, 0, 1,0,0,0, 0, 15'h007B, 0,1, 0,0,0);
    add(1, 4, 0,0,0,0, 0, 15'h007B, 0,1, 0,0,4);
    add(1, 5, 0,0,0,0, 0, 15'h007B, 0,1, 0,4,5);
    add(0, 0, 0,1,0,0, 0, 15'h007B, 1,1, 0,4,5);
    add(0, 0, 0,0,0,0, 0, 15'h007B, 1,1, 0,4,5);
    add(0, 0, 0,0,0,0, 0, 15'h007B, 1,1, 0,4,5);
    add(0, 0, 0,0,0,0, 0, 15'h007B, 1,1, 0,4,5);
    add(0, 0, 0,0,0,0, 1, 15'h7FD3, 1,1, 0,4,5);
    add(1, 9, 1,1,0,0, 1, 15'h7FD3, 1,1, 0,4,5);
    add(0, 0, 0,0,0,1, 0, 15'h7FD3, 0,0, 0,0,0);
    add(1, 1, 0,0,0,0, 0, 15'h7FD3, 0,0, 0,0,1);
    add(1, 2, 0,0,0,0, 0, 15'h7FD3, 0,0, 0,1,2);
    add(1, 3, 0,0,0,0, 0, 15'h7FD3, 0,0, 1,2,3);
    add(1, 4, 0,0,0,0, 0, 15'h7FD3, 0,0, 2,3,4);
    add(1,12, 0,0,0,0, 0, 15'h7FD3, 0,0, 2,3,4);
    add(0, 0, 0,1,0,0, 0, 15'h7FD3, 1,0, 2,3,4);
    add(0, 0, 0,0,0,0, 0, 15'h7FD3, 1,0, 2,3,4);
    add(0, 0, 0,0,0,0, 0, 15'h7FD3, 1,0, 2,3,4);
    add(0, 0, 0,0,0,0, 0, 15'h7FD3, 1,0, 2,3,4);
    add(0, 0, 0,0,0,0, 1, 15'h00EA, 1,0, 2,3,4);
    add(0, 0, 0,0,1,0, 0, 15'h00EA, 0,0, 0,0,0);
    add(1, 9, 0,0,0,0, 0, 15'h00EA, 0,0, 0,0,9);
    add(1, 7, 0,1,0,0, 0, 15'h00EA, 1,0, 0,0,9);
    add(0, 0, 0,0,0,0, 0, 15'h00EA, 1,0, 0,0,9);
    add(0, 0, 0,0,0,0, 0, 15'h00EA, 1,0, 0,0,9);
    add(0, 0, 0,0,0,0, 0, 15'h00EA, 1,0, 0,0,9);
    add(0, 0, 0,0,0,0, 1, 15'h0009, 1,0, 0,0,9);
    add(0, 0, 0,0,0,1, 0, 15'h0009, 0,0, 0,0,0);
    add(0, 0, 0,0,0,1, 0, 15'h0009, 0,0, 0,0,0);
    add(1, 7, 0,0,0,0, 0, 15'h0009, 0,0, 0,0,7);
    add(0, 0, 0,1,0,0, 0, 15'h0009, 1,0, 0,0,7);
    add(0, 0, 0,0,0,1, 0, 15'h0009, 1,0, 0,0,7);
    add(0, 0, 0,0,1,0, 0, 15'h0009, 0,0, 0,0,0);
    add(1, 3, 0,0,0,0, 0, 15'h0009, 0,0, 0,0,3);
    add(1, 5, 1,1,1,0, 0, 15'h0009, 0,0, 0,0,0);
    add(1, 6, 1,0,0,0, 0, 15'h0009, 0,1, 0,0,0);
    add(0, 0, 1,1,0,0, 0, 15'h0009, 1,1, 0,0,0);
    add(0, 0, 0,0,0,0, 0, 15'h0009, 1,1, 0,0,0);
    add(0, 0, 0,0,0,0, 0, 15'h0009, 1,1, 0,0,0);
    add(0, 0, 0,0,0,0, 0, 15'h0009, 1,1, 0,0,0);
    add(0, 0, 0,0,0,0, 1, 15'h0000, 1,1, 0,0,0);
    add(0, 0, 0,0,1,0, 0, 15'h0000, 0,0, 0,0,0);

    foreach (vq[i]) begin
      drive(vq[i].dv, vq[i].d, vq[i].s, vq[i].en, vq[i].cl, vq[i].ak);
      tick;
      check_out($sformatf("vec%0d", i), vq[i].ef, vq[i].ev, vq[i].eb, vq[i].es,
                vq[i].eh, vq[i].et, vq[i].eu);
    end

    // Reset while READY: flag drops without waiting for a clock edge.
    enter_num(9, 9, 9);
    tick; tick; tick; tick;
    check_out("ready_999", 1, 15'h03E7, 1, 0, 9, 9, 9);
    #2 reset = 1'b0;
    #1 check_out("rst_in_ready", 0, '0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;

    // Reset during CONV2, then a fresh entry completes normally.
    tick;
    enter_num(9, 9, 9);
    tick;
    check_out("conv2_busy", 0, '0, 1, 0, 9, 9, 9);
    #2 reset = 1'b0;
    #1 check_out("rst_in_conv", 0, '0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    tick;
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick;
    tick; tick; tick;
    check_out("pre_flag_5", 0, '0, 1, 0, 0, 0, 5);
    tick;
    check_out("after_rst_5", 1, 15'h0005, 1, 0, 0, 0, 5);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick;
    check_out("clear_ready", 0, 15'h0005, 0, 0, 0, 0, 0);

    // Hold/auto-release: count cycles with flag_out high for value 42.
    drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0); tick;
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick;
    hi = 0;
`ifdef ENTRY_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick;
      if (flag_out) hi++;
    end
    checks++;
    if (hi != TMO || flag_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_hold: flag high %0d cycles, final flag=%0b busy=%0b, expected %0d cycles then flag=0 busy=0",
               hi, flag_out, busy, TMO);
    end
`else
    for (int i = 0; i < 103; i++) begin
      tick;
      if (flag_out) hi++;
    end
    checks++;
    if (hi != 100 || flag_out !== 1'b1 || value_out !== 15'h002A) begin
      errors++;
      $display("FAIL hold_100: flag high %0d cycles, final flag=%0b value=%h, expected 100 cycles flag=1 value=002a",
               hi, flag_out, value_out);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); tick;
    check_out("hold_ack", 0, 15'h002A, 0, 0, 0, 0, 0);
`endif

    // Randomized run against the reference model.
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    tick;
    for (int c = 0; c < 3000; c++) begin
      logic dv, s, en, cl, ak;
      int d;
      dv = ($urandom_range(0, 99) < 35);
      d  = $urandom_range(0, 15);
      s  = ($urandom_range(0, 99) < 10);
      en = ($urandom_range(0, 99) < 10);
      cl = ($urandom_range(0, 99) < 4);
      ak = ($urandom_range(0, 99) < 12);
      drive(dv, 4'(d), s, en, cl, ak);
      model_step(dv, d, s, en, cl, ak);
      tick;
      check_out($sformatf("rand%0d", c), (m_e >= 4), m_val, (m_e >= 0), m_s[0],
                4'(m_h), 4'(m_t), 4'(m_u));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
